// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs, FSM states,
// ALU operation classes/codes and datapath select encodings.
package mips_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StIExec  = 4'd10,
    StIWb    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    AluOpAdd,
    AluOpSub,
    AluOpAnd,
    AluOpOr,
    AluOpSlt,
    AluOpFunct
  } aluOp_t;

  localparam logic [3:0] AluCodeAnd = 4'b0000;
  localparam logic [3:0] AluCodeOr  = 4'b0001;
  localparam logic [3:0] AluCodeAdd = 4'b0010;
  localparam logic [3:0] AluCodeSub = 4'b0110;
  localparam logic [3:0] AluCodeSlt = 4'b0111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_ctr.sv
// ALU control decode: maps an operation class (or R-type Funct) to the ALU code,
// zero-extended to ALU_CTRL_W, and flags whether Funct is a supported R-type function.
module alu_ctr
  import mips_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic [5:0]            Funct,
  input  logic [2:0]            aluOp,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  functLegal
);

  logic [3:0] functCode;
  logic [3:0] code;

  always_comb begin
    functLegal = 1'b1;
    functCode  = AluCodeAdd;
    case (Funct)
      FnAdd:   functCode = AluCodeAdd;
      FnSub:   functCode = AluCodeSub;
      FnAnd:   functCode = AluCodeAnd;
      FnOr:    functCode = AluCodeOr;
      FnSlt:   functCode = AluCodeSlt;
      default: functLegal = 1'b0;
    endcase
  end

  always_comb begin
    code = AluCodeAdd;
    case (aluOp_t'(aluOp))
      AluOpSub:   code = AluCodeSub;
      AluOpAnd:   code = AluCodeAnd;
      AluOpOr:    code = AluCodeOr;
      AluOpSlt:   code = AluCodeSlt;
      AluOpFunct: code = functCode;
      default:    code = AluCodeAdd;
    endcase
  end

  assign ALUControl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back
// and driving datapath enables, selects and ALU control each cycle.
module multi_cycle_ctr
  import mips_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter bit          HAS_BNE    = 1'b1,
  parameter bit          HAS_IMM    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            OpCode,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  IorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  RegDst,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  ExtOp,
  output logic [1:0]            PCSource,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  IllegalOp,
  output logic [3:0]            State
);

  state_t stateQ, stateD, curState;
  aluOp_t aluOp, immAluOp;
  logic   isImm, immExt, functLegal;

  always_ff @(posedge clk) begin
    if (reset) stateQ <= StFetch;
    else       stateQ <= stateD;
  end

  // During reset the outputs present the FETCH decode (enables masked below).
  assign curState = reset ? StFetch : stateQ;
  assign State    = curState;

  alu_ctr #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_ctr (
    .Funct      (Funct),
    .aluOp      (aluOp),
    .ALUControl (ALUControl),
    .functLegal (functLegal)
  );

  always_comb begin
    isImm    = HAS_IMM;
    immAluOp = AluOpAdd;
    immExt   = 1'b1;
    case (OpCode)
      OpAddi:  immAluOp = AluOpAdd;
      OpSlti:  immAluOp = AluOpSlt;
      OpAndi:  begin immAluOp = AluOpAnd; immExt = 1'b0; end
      OpOri:   begin immAluOp = AluOpOr;  immExt = 1'b0; end
      default: isImm = 1'b0;
    endcase
  end

  always_comb begin
    stateD    = curState;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SrcBReg;
    ExtOp     = 1'b0;
    PCSource  = PcSrcAlu;
    aluOp     = AluOpAdd;
    IllegalOp = 1'b0;

    unique case (curState)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBFour;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          stateD  = StDecode;
        end
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh;
        ExtOp   = 1'b1;
        stateD  = StFetch;
        case (OpCode)
          OpLw, OpSw: stateD = StMemAdr;
          OpRType:    if (functLegal) stateD = StExec; else IllegalOp = 1'b1;
          OpBeq:      stateD = StBranch;
          OpBne:      if (HAS_BNE) stateD = StBranch; else IllegalOp = 1'b1;
          OpJ:        stateD = StJump;
          default:    if (isImm) stateD = StIExec; else IllegalOp = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        ExtOp   = 1'b1;
        stateD  = (OpCode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) stateD = StMemWb;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        stateD   = StFetch;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) stateD = StFetch;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        aluOp   = AluOpFunct;
        stateD  = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        stateD   = StFetch;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        aluOp    = AluOpSub;
        PCSource = PcSrcAluOut;
        PCWrite  = (HAS_BNE && OpCode == OpBne) ? ~Zero : Zero;
        stateD   = StFetch;
      end
      StJump: begin
        PCSource = PcSrcJump;
        PCWrite  = 1'b1;
        stateD   = StFetch;
      end
      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        aluOp   = immAluOp;
        ExtOp   = immExt;
        stateD  = StIWb;
      end
      StIWb: begin
        RegWrite = 1'b1;
        aluOp    = immAluOp;
        ExtOp    = immExt;
        stateD   = StFetch;
      end
      default: stateD = StFetch;
    endcase

    if (reset) begin
      PCWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Scoreboard bench for multi_cycle_ctr: directed per-cycle expectations are queued by the
// stimulus and compared by a negedge monitor; a second instance covers HAS_BNE/HAS_IMM=0.
module tb_multi_cycle_ctr;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic       m2r;
    logic       rdst;
    logic       srcA;
    logic [1:0] srcB;
    logic       ext;
    logic [1:0] pcs;
    logic [3:0] alu;
    logic       ill;
  } exp_t;

  typedef struct packed {
    exp_t       e;
    logic       chk2;
    logic [3:0] st2;
    logic       ill2;
    logic [4:0] alu2;
  } item_t;

  logic clk = 1'b0;
  logic reset, Zero, MemReady;
  logic [5:0] OpCode, Funct;

  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, ALUSrcA;
  logic ExtOp, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUControl, State;

  logic d2PCWrite, d2IorD, d2MemRead, d2MemWrite, d2IRWrite, d2RegWrite, d2MemtoReg;
  logic d2RegDst, d2ALUSrcA, d2ExtOp, d2IllegalOp;
  logic [1:0] d2ALUSrcB, d2PCSource;
  logic [4:0] d2ALUControl;
  logic [3:0] d2State;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  always #5 clk = ~clk;

  multi_cycle_ctr dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
    .PCSource(PCSource), .ALUControl(ALUControl), .IllegalOp(IllegalOp), .State(State)
  );

  multi_cycle_ctr #(.ALU_CTRL_W(5), .HAS_BNE(1'b0), .HAS_IMM(1'b0)) dut2 (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(d2PCWrite), .IorD(d2IorD), .MemRead(d2MemRead),
    .MemWrite(d2MemWrite), .IRWrite(d2IRWrite), .RegWrite(d2RegWrite),
    .MemtoReg(d2MemtoReg), .RegDst(d2RegDst), .ALUSrcA(d2ALUSrcA), .ALUSrcB(d2ALUSrcB),
    .ExtOp(d2ExtOp), .PCSource(d2PCSource), .ALUControl(d2ALUControl),
    .IllegalOp(d2IllegalOp), .State(d2State)
  );

  // Hand-written per-state output tables.
  function automatic exp_t sFetch(input logic mr, input logic inReset);
    exp_t e = '0;
    e.st = 4'd0; e.mrd = !inReset; e.srcB = 2'b01; e.alu = 4'b0010;
    e.irw = mr && !inReset; e.pcw = mr && !inReset;
    return e;
  endfunction
  function automatic exp_t sDecode(input logic ill);
    exp_t e = '0;
    e.st = 4'd1; e.srcB = 2'b11; e.ext = 1'b1; e.alu = 4'b0010; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t sMemAdr();
    exp_t e = '0;
    e.st = 4'd2; e.srcA = 1'b1; e.srcB = 2'b10; e.ext = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sMemRd();
    exp_t e = '0;
    e.st = 4'd3; e.iord = 1'b1; e.mrd = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sMemWb();
    exp_t e = '0;
    e.st = 4'd4; e.rgw = 1'b1; e.m2r = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sMemWr();
    exp_t e = '0;
    e.st = 4'd5; e.iord = 1'b1; e.mwr = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sExec(input logic [3:0] alu);
    exp_t e = '0;
    e.st = 4'd6; e.srcA = 1'b1; e.alu = alu;
    return e;
  endfunction
  function automatic exp_t sAluWb();
    exp_t e = '0;
    e.st = 4'd7; e.rgw = 1'b1; e.rdst = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sBranch(input logic pcw);
    exp_t e = '0;
    e.st = 4'd8; e.srcA = 1'b1; e.alu = 4'b0110; e.pcs = 2'b01; e.pcw = pcw;
    return e;
  endfunction
  function automatic exp_t sJump();
    exp_t e = '0;
    e.st = 4'd9; e.pcs = 2'b10; e.pcw = 1'b1; e.alu = 4'b0010;
    return e;
  endfunction
  function automatic exp_t sIExec(input logic [3:0] alu, input logic ext);
    exp_t e = '0;
    e.st = 4'd10; e.srcA = 1'b1; e.srcB = 2'b10; e.alu = alu; e.ext = ext;
    return e;
  endfunction
  function automatic exp_t sIWb(input logic [3:0] alu, input logic ext);
    exp_t e = '0;
    e.st = 4'd11; e.rgw = 1'b1; e.alu = alu; e.ext = ext;
    return e;
  endfunction

  task automatic cyc2(input logic r, input logic mr, input logic zr, input exp_t e,
                      input logic c2, input logic [3:0] s2, input logic i2);
    item_t it;
    reset = r; MemReady = mr; Zero = zr;
    it.e = e; it.chk2 = c2; it.st2 = s2; it.ill2 = i2; it.alu2 = 5'b00010;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic mr, input logic zr, input exp_t e);
    cyc2(r, mr, zr, e, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic setInstr(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op; Funct = fn;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      exp_t act;
      it = q.pop_front();
      stepNo++;
      act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst,
             ALUSrcA, ALUSrcB, ExtOp, PCSource, ALUControl, IllegalOp};
      checks++;
      if (act !== it.e) begin
        errors++;
        $display("FAIL step%0d outputs: got %h want %h", stepNo, act, it.e);
      end
      if (it.chk2) begin
        checks++;
        if ({d2State, d2IllegalOp, d2ALUControl} !== {it.st2, it.ill2, it.alu2}) begin
          errors++;
          $display("FAIL step%0d dut2 st/ill/alu: got %h/%b/%b want %h/%b/%b", stepNo,
                   d2State, d2IllegalOp, d2ALUControl, it.st2, it.ill2, it.alu2);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
    setInstr(6'b000101, 6'b000000);
    @(posedge clk);
    #1;
    // Reset held two cycles; both instances in FETCH view with enables off.
    cyc2(1, 1, 1, sFetch(1, 1), 1, 4'd0, 0);
    cyc2(1, 1, 1, sFetch(1, 1), 1, 4'd0, 0);
    // bne with Zero=1: not taken on dut, illegal on the no-bne instance.
    cyc2(0, 1, 1, sFetch(1, 0), 1, 4'd0, 0);
    cyc2(0, 1, 1, sDecode(0), 1, 4'd1, 1);
    cyc2(0, 1, 1, sBranch(0), 1, 4'd0, 0);

    // lw: 0,1,2,3,4
    setInstr(6'b100011, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0)); cyc(0, 1, 0, sMemAdr());
    cyc(0, 1, 0, sMemRd());     cyc(0, 1, 0, sMemWb());

    // sw with a fetch stall, then two stall cycles in MEMWR
    setInstr(6'b101011, 6'b000000);
    cyc(0, 0, 0, sFetch(0, 0)); cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0));
    cyc(0, 1, 0, sMemAdr());    cyc(0, 0, 0, sMemWr());     cyc(0, 0, 0, sMemWr());
    cyc(0, 1, 0, sMemWr());

    // beq taken, bne taken (Zero=0)
    setInstr(6'b000100, 6'b000000);
    cyc(0, 1, 1, sFetch(1, 0)); cyc(0, 1, 1, sDecode(0)); cyc(0, 1, 1, sBranch(1));
    setInstr(6'b000101, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0)); cyc(0, 1, 0, sBranch(1));

    // j; MemReady low outside FETCH/MEMRD/MEMWR is ignored
    setInstr(6'b000010, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 0, 0, sDecode(0)); cyc(0, 0, 0, sJump());

    // R-type slt and sub
    setInstr(6'b000000, 6'b101010);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0)); cyc(0, 1, 0, sExec(4'b0111));
    cyc(0, 1, 0, sAluWb());
    setInstr(6'b000000, 6'b100010);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0)); cyc(0, 1, 0, sExec(4'b0110));
    cyc(0, 1, 0, sAluWb());

    // I-type: ori, addi, slti, andi
    setInstr(6'b001101, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0));
    cyc(0, 1, 0, sIExec(4'b0001, 0)); cyc(0, 1, 0, sIWb(4'b0001, 0));
    setInstr(6'b001000, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0));
    cyc(0, 1, 0, sIExec(4'b0010, 1)); cyc(0, 1, 0, sIWb(4'b0010, 1));
    setInstr(6'b001010, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0));
    cyc(0, 1, 0, sIExec(4'b0111, 1)); cyc(0, 1, 0, sIWb(4'b0111, 1));
    setInstr(6'b001100, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0));
    cyc(0, 1, 0, sIExec(4'b0000, 0)); cyc(0, 1, 0, sIWb(4'b0000, 0));

    // Illegal opcode and illegal Funct: one-cycle pulse, back to FETCH
    setInstr(6'b111111, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(1));
    setInstr(6'b000000, 6'b000111);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(1));

    // lw interrupted by reset while stalled in MEMRD
    setInstr(6'b100011, 6'b000000);
    cyc(0, 1, 0, sFetch(1, 0)); cyc(0, 1, 0, sDecode(0)); cyc(0, 1, 0, sMemAdr());
    cyc(0, 0, 0, sMemRd());     cyc(1, 0, 0, sFetch(0, 1)); cyc(0, 1, 0, sFetch(1, 0));
    cyc(0, 1, 0, sDecode(0));

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctr.md
# multi_cycle_ctr

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the datapath enables, mux selects and ALU operation each cycle. It succeeds the single-cycle combinational decoder. It adds bne, I-type ALU ops, a memory wait handshake, illegal-instruction flagging and a parametrised ALU control width. It sits between the instruction register (OpCode/Funct) and the shared multi-cycle datapath.

## Interface
- ALU_CTRL_W, 4: width of ALUControl; must be ≥4; codes are zero-extended.
- HAS_BNE, 1: 1 decodes bne (000101); 0 treats it as illegal.
- HAS_IMM, 1: 1 decodes addi/andi/ori/slti; 0 treats them as illegal.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, sampled in BRANCH.
- MemReady  in  1  memory completes the access this cycle.
- PCWrite  out  1  PC load enable (already branch-resolved).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite  out  1 each  enables.
- MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination select: 0 = rt, 1 = rd.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign/zero-extended immediate, 11 = extended immediate << 2.
- ExtOp  out  1  1 = sign extend, 0 = zero extend.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUControl  out  ALU_CTRL_W  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- IllegalOp  out  1  one-cycle pulse on an undecodable instruction.
- State  out  4  current state, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
  - EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALU ADD, PCSource=00.
  - IRWrite and PCWrite are asserted only when MemReady=1; otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALU ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw (100011/101011) → MEMADR.
  - R-type (000000) with a legal Funct → EXEC.
  - beq (000100), or bne (000101) if HAS_BNE → BRANCH.
  - j (000010) → JUMP.
  - addi 001000, slti 001010, andi 001100, ori 001101 (if HAS_IMM) → IEXEC.
  - Anything else: IllegalOp=1 for this cycle, then → FETCH. PC already holds PC+4, so the instruction acts as a NOP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: IorD=1, MemRead=1; held until MemReady=1, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: IorD=1, MemWrite=1; held until MemReady=1, then → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00; ALUControl from Funct (add 100000, sub 100010, and 100100, or 100101, slt 101010) → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01.
  - PCWrite = Zero for beq, ~Zero for bne. Then → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. addi ADD/sign, slti SLT/sign, andi AND/zero, ori OR/zero → IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. ALUControl and ExtOp are held from IEXEC → FETCH.
- Any output not listed for a state is 0; ALUControl defaults to ADD.

## Timing
- State register updates on the clk rising edge. Outputs decode combinationally from the state, plus Funct/OpCode/Zero/MemReady where listed above.
- reset=1 at an edge puts the FSM in FETCH, including mid-instruction.
  - While reset=1, all enables (PCWrite, MemRead, MemWrite, IRWrite, RegWrite) and IllegalOp are forced to 0.
  - All other outputs show their FETCH values.
- Latency with MemReady tied to 1:
  - lw 5 cycles.
  - sw, R-type and I-type 4 cycles.
  - beq/bne and j 3 cycles.
  - Illegal instruction 2 cycles.
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. During those cycles outputs hold steady and no register or PC is written.
- MemReady is ignored in every other state.
- OpCode/Funct must stay stable from DECODE to instruction end; the IR is written only in FETCH.

## Structure
- Shared package mips_pkg holds:
  - Opcode and Funct constants.
  - State encodings.
  - ALU operation codes.
  - ALUSrcB and PCSource select encodings.
- Sub-module alu_ctr decodes (Funct, ALU op class) into ALUControl and a legal-Funct flag. It is purely combinational and parametrised by ALU_CTRL_W.

## Test plan
- reset held 2 cycles, then released with MemReady=1 → State=0, then MemRead=1, IRWrite=1, PCWrite=1 in the first cycle; no write enables during reset.
- lw (OpCode 100011) → State sequence 0,1,2,3,4; MEMWB asserts RegWrite=1, MemtoReg=1, RegDst=0.
- sw with MemReady low for 2 cycles in MEMWR → MemWrite=1 held for 3 cycles, total latency 6 cycles, PCWrite=0 during the stall.
- beq with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. bne with Zero=1 → PCWrite=0. With HAS_BNE=0, bne → IllegalOp pulse and return to FETCH.
- R-type slt (Funct 101010) → ALUControl=0111 in EXEC; ori (001101) → ALUControl=0001 and ExtOp=0 in IEXEC and IWB.
- OpCode 111111, or R-type Funct 000111 → IllegalOp=1 for exactly one DECODE cycle, RegWrite/MemWrite never asserted; reset asserted mid-MEMRD → FETCH on the next edge.
